// File: rtl/daq_event_packer.sv
// -----------------------------------------------------------------------------
// daq_event_packer
//
// Buffers the framed 64-bit event stream (header, body..., trailer) coming from
// the data transfer manager and forwards it to the DAQ link serializer.
// The write side checks the framing, drops misplaced words and stamps the event
// length into trailer bits [19:0]. The read side pops one word per cycle
// whenever the FIFO holds data and the link is not almost full.
//
// Optional feature: define DAQ_EVENT_CRC16_EN to replace trailer bits [47:32]
// with a CRC-16-CCITT (0x1021, init 0xFFFF, MSB first) of the event's
// header and body words.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   daq_data[63:0]    incoming event word
//   daq_valid         incoming word valid
//   daq_header        incoming word is a header
//   daq_trailer       incoming word is a trailer
//   daq_ready         a word can be accepted this cycle
//   link_data[63:0]   word to the link (registered)
//   link_valid        one-cycle strobe per link word
//   link_header       link word is a header
//   link_trailer      link word is a trailer
//   link_almost_full  link cannot take more words
//   err_framing       one-cycle pulse per framing error
//   event_count[31:0] trailers written since reset (wraps)
// -----------------------------------------------------------------------------
module daq_event_packer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] daq_data,
    input  logic        daq_valid,
    input  logic        daq_header,
    input  logic        daq_trailer,
    output logic        daq_ready,
    output logic [63:0] link_data,
    output logic        link_valid,
    output logic        link_header,
    output logic        link_trailer,
    input  logic        link_almost_full,
    output logic        err_framing,
    output logic [31:0] event_count
);

    typedef enum logic [0:0] {
        WAIT_HDR = 1'b0,
        IN_EVENT = 1'b1
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [AW:0]  r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [65:0]  r_mem [DEPTH];     // {header, trailer, data}
    logic [19:0]  r_len;
    logic [19:0]  w_len_nxt;
    logic [19:0]  w_len_inc;
    logic         w_acc;
    logic         w_pop;
    logic         w_write;
    logic         w_err;
    logic         w_ev_inc;
    logic [65:0]  w_wentry;
    logic         r_err;
    logic [31:0]  r_event_count;
    logic [63:0]  r_link_data;
    logic         r_link_valid;
    logic         r_link_header;
    logic         r_link_trailer;

`ifdef DAQ_EVENT_CRC16_EN
    logic [15:0]  r_crc;
    logic [15:0]  w_crc_nxt;

    // CRC-16-CCITT advanced over one 64-bit word, most significant bit first
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [63:0] data_in);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ data_in[i];
            c  = {c[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
        end
        return c;
    endfunction
`endif

    assign daq_ready    = (r_count != FULL_CNT);
    assign w_acc        = daq_valid && daq_ready;
    assign w_pop        = (r_count != {(AW+1){1'b0}}) && !link_almost_full;
    // Length saturates instead of wrapping on absurdly long events
    assign w_len_inc    = (r_len == 20'hFFFFF) ? r_len : (r_len + 20'd1);

    assign link_data    = r_link_data;
    assign link_valid   = r_link_valid;
    assign link_header  = r_link_header;
    assign link_trailer = r_link_trailer;
    assign err_framing  = r_err;
    assign event_count  = r_event_count;

    // Framing FSM: next state, FIFO write decision and trailer stamping
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_write     = 1'b0;
        w_err       = 1'b0;
        w_ev_inc    = 1'b0;
        w_wentry    = {1'b0, 1'b0, daq_data};
`ifdef DAQ_EVENT_CRC16_EN
        w_crc_nxt   = r_crc;
`endif
        if (w_acc) begin
            if (daq_header && daq_trailer) begin
                w_err = 1'b1;
            end else if (daq_header) begin
                // A header inside an event abandons the old one
                w_err       = (r_state == IN_EVENT);
                w_write     = 1'b1;
                w_wentry    = {1'b1, 1'b0, daq_data};
                w_len_nxt   = 20'd1;
                w_state_nxt = IN_EVENT;
`ifdef DAQ_EVENT_CRC16_EN
                w_crc_nxt   = crc16_word(16'hFFFF, daq_data);
`endif
            end else if (r_state == WAIT_HDR) begin
                w_err = 1'b1;
            end else if (daq_trailer) begin
                w_write     = 1'b1;
                w_wentry    = {1'b0, 1'b1, daq_data[63:20], w_len_inc};
`ifdef DAQ_EVENT_CRC16_EN
                w_wentry[47:32] = r_crc;
`endif
                w_ev_inc    = 1'b1;
                w_len_nxt   = 20'd0;
                w_state_nxt = WAIT_HDR;
            end else begin
                w_write     = 1'b1;
                w_len_nxt   = w_len_inc;
`ifdef DAQ_EVENT_CRC16_EN
                w_crc_nxt   = crc16_word(r_crc, daq_data);
`endif
            end
        end else begin
            w_write = 1'b0;
        end
    end

    // FSM state, event length, error pulse and event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= WAIT_HDR;
            r_len         <= 20'd0;
            r_err         <= 1'b0;
            r_event_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_err         <= w_err;
            r_event_count <= r_event_count + {31'd0, w_ev_inc};
        end
    end

`ifdef DAQ_EVENT_CRC16_EN
    // Running CRC of the current event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 16'hFFFF;
        end else begin
            r_crc <= w_crc_nxt;
        end
    end
`endif

    // FIFO storage; contents are don't-care until written, pointers define validity
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_wentry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Link output register: data/flags hold between pops, valid is a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_data    <= 64'd0;
            r_link_header  <= 1'b0;
            r_link_trailer <= 1'b0;
            r_link_valid   <= 1'b0;
        end else if (w_pop) begin
            r_link_data    <= r_mem[r_rd_ptr][63:0];
            r_link_header  <= r_mem[r_rd_ptr][65];
            r_link_trailer <= r_mem[r_rd_ptr][64];
            r_link_valid   <= 1'b1;
        end else begin
            r_link_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_daq_event_packer.sv
module tb_daq_event_packer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] daq_data = 64'd0;
    logic        daq_valid = 1'b0;
    logic        daq_header = 1'b0;
    logic        daq_trailer = 1'b0;
    logic        daq_ready;
    logic [63:0] link_data;
    logic        link_valid;
    logic        link_header;
    logic        link_trailer;
    logic        link_almost_full = 1'b0;
    logic        err_framing;
    logic [31:0] event_count;

    daq_event_packer #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .daq_data(daq_data), .daq_valid(daq_valid),
        .daq_header(daq_header), .daq_trailer(daq_trailer),
        .daq_ready(daq_ready),
        .link_data(link_data), .link_valid(link_valid),
        .link_header(link_header), .link_trailer(link_trailer),
        .link_almost_full(link_almost_full),
        .err_framing(err_framing), .event_count(event_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (event-level view) ----------------
    logic [65:0] sb[$];          // expected link words {hdr, trl, data}
    logic [63:0] m_words[$];     // words of the event in progress
    int          m_occ;
    bit          m_in_event;
    int          m_len;
    logic [31:0] m_ev;
    bit          m_lv;
    bit          m_err;

    int n_chk = 0;
    int n_pass = 0;
    int n_timeouts = 0;
    bit rnd_mode = 1'b0;

`ifdef DAQ_EVENT_CRC16_EN
    function automatic logic [15:0] ref_crc(input logic [63:0] w[$]);
        logic [15:0] crc;
        logic [63:0] word;
        logic [7:0]  byte_v;
        crc = 16'hFFFF;
        foreach (w[k]) begin
            word = w[k];
            for (int b = 7; b >= 0; b--) begin
                byte_v = word[b*8 +: 8];
                crc = crc ^ {byte_v, 8'h00};
                for (int j = 0; j < 8; j++)
                    crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
            end
        end
        return crc;
    endfunction
`endif

    always @(posedge clk or negedge rst_n) begin
        bit          acc;
        bit          pop;
        logic [63:0] tr;
        int          stamped;
        if (!rst_n) begin
            sb.delete();
            m_words.delete();
            m_occ = 0; m_in_event = 0; m_len = 0;
            m_ev = 32'd0; m_lv = 0; m_err = 0;
        end else begin
            pop   = (m_occ > 0) && !link_almost_full;
            acc   = daq_valid && (m_occ != DEPTH);
            m_lv  = pop;
            m_err = 0;
            if (acc) begin
                if (daq_header && daq_trailer) begin
                    m_err = 1;
                end else if (daq_header) begin
                    m_err = m_in_event;
                    m_in_event = 1;
                    m_len = 1;
                    m_words.delete();
                    m_words.push_back(daq_data);
                    sb.push_back({1'b1, 1'b0, daq_data});
                end else if (!m_in_event) begin
                    m_err = 1;
                    acc = 0;
                end else if (daq_trailer) begin
                    stamped = (m_len + 1 > 'hFFFFF) ? 'hFFFFF : m_len + 1;
                    tr = daq_data;
                    tr[19:0] = stamped[19:0];
`ifdef DAQ_EVENT_CRC16_EN
                    tr[47:32] = ref_crc(m_words);
`endif
                    sb.push_back({1'b0, 1'b1, tr});
                    m_ev = m_ev + 32'd1;
                    m_in_event = 0;
                end else begin
                    m_len = m_len + 1;
                    m_words.push_back(daq_data);
                    sb.push_back({1'b0, 1'b0, daq_data});
                end
                if (daq_header && daq_trailer) acc = 0;
            end
            m_occ = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk or negedge rst_n) begin
        logic [65:0] e;
        if (!rst_n) begin
            #1;
            chk("rst_link_valid",   {65'd0, link_valid},   66'd0);
            chk("rst_link_header",  {65'd0, link_header},  66'd0);
            chk("rst_link_trailer", {65'd0, link_trailer}, 66'd0);
            chk("rst_link_data",    {2'd0, link_data},     66'd0);
            chk("rst_err",          {65'd0, err_framing},  66'd0);
            chk("rst_event_count",  {34'd0, event_count},  66'd0);
            chk("rst_ready",        {65'd0, daq_ready},    66'd1);
        end else begin
            chk("daq_ready",  {65'd0, daq_ready},  {65'd0, (m_occ != DEPTH)});
            chk("link_valid", {65'd0, link_valid}, {65'd0, m_lv});
            if (link_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: got word %h expected none", link_data);
                end else begin
                    e = sb.pop_front();
                    chk("link_word", {link_header, link_trailer, link_data}, e);
                end
            end
            chk("err_framing", {65'd0, err_framing}, {65'd0, m_err});
            chk("event_count", {34'd0, event_count}, {34'd0, m_ev});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [63:0] d, input logic h, input logic t);
        int guard;
        guard = 0;
        @(negedge clk);
        daq_data = d; daq_header = h; daq_trailer = t; daq_valid = 1'b1;
        if (rnd_mode) link_almost_full = ($urandom_range(0, 3) == 0);
        while (!daq_ready) begin
            @(negedge clk);
            if (rnd_mode) link_almost_full = ($urandom_range(0, 3) == 0);
            guard++;
            if (guard > 300) begin
                n_timeouts++;
                $display("FAIL send_timeout: got daq_ready stuck low expected high");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        daq_valid = 1'b0; daq_header = 1'b0; daq_trailer = 1'b0;
        if (rnd_mode) link_almost_full = ($urandom_range(0, 3) == 0);
        repeat (n - 1) @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // orphan body word right after reset
        send(64'h1234, 1'b0, 1'b0);
        idle(4);

        // basic event
        send(64'h0000_0123_0000_0008, 1'b1, 1'b0);
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
        send(64'h5555_5555_5555_5555, 1'b0, 1'b0);
        send(64'h0000_0000_0C00_0008, 1'b0, 1'b1);
        idle(6);

        // nested header
        send(rnd64(), 1'b1, 1'b0);
        send(rnd64(), 1'b0, 1'b0);
        send(rnd64(), 1'b1, 1'b0);
        send(rnd64(), 1'b0, 1'b0);
        send(rnd64(), 1'b0, 1'b1);
        idle(8);

        // CRC event with all-zero payloads
        send(64'd0, 1'b1, 1'b0);
        send(64'd0, 1'b0, 1'b0);
        send(64'd0, 1'b0, 1'b1);
        idle(6);

        // backpressure: 20 words with the link almost full, then release
        @(negedge clk);
        link_almost_full = 1'b1;
        fork
            begin
                send(rnd64(), 1'b1, 1'b0);
                for (int i = 0; i < 18; i++) send(rnd64(), 1'b0, 1'b0);
                send(rnd64(), 1'b0, 1'b1);
                idle(1);
            end
            begin
                repeat (30) @(negedge clk);
                link_almost_full = 1'b0;
            end
        join
        idle(30);

        // reset in the middle of an event, then a stray trailer
        send(rnd64(), 1'b1, 1'b0);
        send(rnd64(), 1'b0, 1'b0);
        send(rnd64(), 1'b0, 1'b0);
        @(negedge clk);
        daq_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(rnd64(), 1'b0, 1'b1);
        idle(6);

        // randomized events with framing faults and link backpressure
        rnd_mode = 1'b1;
        for (int ev = 0; ev < 40; ev++) begin
            int nbody;
            if ($urandom_range(0, 7) == 0) send(rnd64(), 1'b0, $urandom_range(0, 1) == 1);
            send(rnd64(), 1'b1, 1'b0);
            nbody = $urandom_range(0, 6);
            for (int b = 0; b < nbody; b++) begin
                if ($urandom_range(0, 9) == 0) send(rnd64(), 1'b1, 1'b1);
                if ($urandom_range(0, 11) == 0) send(rnd64(), 1'b1, 1'b0);
                send(rnd64(), 1'b0, 1'b0);
            end
            send(rnd64(), 1'b0, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(1);
        rnd_mode = 1'b0;
        @(negedge clk);
        link_almost_full = 1'b0;
        repeat (40) @(negedge clk);

        n_chk++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d words left expected 0", sb.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk + n_timeouts);
        $finish;
    end

endmodule
